fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch sequencer for the RV32E core. It owns the program counter, drives the address bus of the combinational program ROM, and buffers fetched words in a small prefetch FIFO. It presents them to decode over a valid/ready handshake and flushes and restarts on branch/jump redirects. It sits between `mem_program_rom` and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `FIFO_DEPTH`, 2, prefetch entries (power of two, ≥2)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `fetch_en`  in  1  allow new ROM fetches; buffered entries still drain when low
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  32  redirect target byte address
- `rom_addr`  out  32  byte address to program ROM (ROM ignores bits [1:0])
- `rom_data`  in  32  ROM word, valid combinationally in the same cycle
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode accepts head
- `instr`  out  32  instruction word at head
- `instr_pc`  out  32  byte address of `instr`
- `fault`  out  1  misaligned-redirect fault (tied 0 without macro)

## Operation
- `fetch_pc` register drives `rom_addr` continuously.
- Push condition: `fetch_en & !redirect_valid & !faulted & (count<FIFO_DEPTH | pop)`. On push, `{fetch_pc, rom_data}` is written and `fetch_pc <= fetch_pc + 4`, with 32-bit wrap.
- Pop when `instr_valid & instr_ready`.
- Push and pop can occur in the same cycle at any count, including full.
- Redirect has the highest priority:
  - FIFO is cleared and `count <= 0`.
  - A same-cycle pop is discarded. A pop is still counted as consumed by decode, and decode ignores it.
  - No push occurs.
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
- `fetch_en` low: `fetch_pc` holds and no push occurs. Pops continue.
- States: RUN and FAULTED. FAULTED is reachable only with the macro (see Configuration).
- Reset values: `fetch_pc=RESET_PC`, `count=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`, `fault=0`, state RUN.
- Reset asserted mid-operation clears everything asynchronously. In-flight entries are lost.
- When the FIFO is empty, `instr` and `instr_pc` output 0.

## Timing
- Fetch-to-valid: a word pushed at edge N is visible on `instr`/`instr_valid` after edge N, i.e. in cycle N+1.
- After reset release with `fetch_en=1`, `instr_valid` rises after the first clock edge.
- Redirect asserted in cycle N:
  - `instr_valid=0` in cycle N+1.
  - Target word is fetched in N+1 and valid in N+2.
  - Redirect penalty is 2 cycles.
- Sustained throughput is 1 instruction/cycle with `instr_ready` held high and `FIFO_DEPTH≥2`.
- `instr_valid` stays high until popped or flushed, and `instr`/`instr_pc` stay stable while stalled.
- No combinational path from `instr_ready` to `rom_addr`.

## Configuration
- `FETCH_ALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]!=0` clears the FIFO, enters FAULTED and sets `fault=1` from the next cycle.
  - In FAULTED, no fetches occur.
  - An aligned redirect returns to RUN and clears `fault`, then fetches normally.
  - A misaligned redirect while already FAULTED stays in FAULTED.
- `FETCH_ALIGN_TRAP_EN` undefined:
  - Low two bits of `redirect_pc` are silently dropped, matching the ROM's forced word alignment.
  - `fault` is constant 0 and the FAULTED state is not synthesised.

## Structure
- Shared package `rv32e_pkg`:
  - `I_NOP` encoding.
  - `PC_STEP=4`.
  - `fetch_state_t` enum {RUN, FAULTED}.
  - ROM depth constant `PROG_ROM_WORDS=512`.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with 64-bit entries `{pc,instr}`, a `flush` input, and simultaneous push/pop at full. `fetch_sequencer` instantiates one.

## Test plan
- Reset, ROM word 0 = 32'hF0CAC137, `fetch_en=1`, `instr_ready=1` → cycle 1 `instr=32'hF0CAC137`, `instr_pc=0`. Then `instr_pc` is 4, 8, 12 on consecutive cycles.
- Hold `instr_ready=0` for 5 cycles → FIFO fills to 2, `rom_addr` freezes at 8, and `instr`/`instr_pc=0` stay stable. Release `instr_ready` → pcs 0, 4, 8 arrive with no gaps or duplicates.
- Redirect to 32'h1C while the FIFO holds pcs 4 and 8 → `instr_valid=0` the next cycle, then `instr_pc=32'h1C`. Entries 4 and 8 are never presented.
- Redirect in the same cycle as a pop at full, and simultaneous push/pop at full → count is correct with no lost or duplicated words.
- Misaligned redirect to 32'h1E with the macro defined → `fault=1` with no fetches. An aligned redirect to 32'h20 then clears `fault` and `instr_pc=32'h20`. Without the macro → `instr_pc=32'h1C` and `fault=0`.
- Assert `rst` mid-stream with FIFO full → `instr_valid=0` immediately (asynchronously). After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/rv32e_pkg.sv
// rtl/rv32e_pkg.sv - shared RV32E fetch-path constants and types
package rv32e_pkg;

  localparam logic [31:0] I_NOP          = 32'h0000_0013;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam int          PROG_ROM_WORDS = 512;

  typedef enum logic {
    RUN     = 1'b0,
    FAULTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc,instr} entries with flush and push/pop at full
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32E instruction-fetch sequencer; optional FETCH_ALIGN_TRAP_EN traps misaligned redirects
module fetch_sequencer
  import rv32e_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [63:0]   head_data;
  logic          head_valid;
  logic          faulted;
  logic          push;
  logic          pop;

`ifdef FETCH_ALIGN_TRAP_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    faulted = (state_q == FAULTED);
    if (redirect_valid) begin
      state_d = (redirect_pc[1:0] != 2'b00) ? FAULTED : RUN;
    end
  end
`else
  assign faulted = 1'b0;
`endif

  assign fault = faulted;

  // Push may depend on instr_ready via pop, but only fetch_pc's next value sees it.
  assign pop  = head_valid & instr_ready;
  assign push = fetch_en & ~redirect_valid & ~faulted &
                ((count < CW'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({fetch_pc, rom_data}),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (count)
  );

  assign rom_addr    = fetch_pc;
  assign instr_valid = head_valid;
  assign instr       = head_valid ? head_data[31:0]  : 32'h0;
  assign instr_pc    = head_valid ? head_data[63:32] : 32'h0;

endmodule
